// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron layer: FSM states, index widths, post-processing.
package perceptron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_POST,
    ST_OUT
  } state_e;

  localparam int MAX_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic shift, optional ReLU, then clamp to the signed out_w range.
  function automatic logic signed [MAX_W-1:0] shift_relu_sat(
    input logic signed [MAX_W-1:0] v,
    input int                      frac,
    input int                      out_w,
    input logic                    relu
  );
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (relu && (s < 0)) s = '0;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_layer_weight_bank.sv
// One neuron's weight store: 1W1R synchronous RAM, 1-cycle read latency, contents not reset.
module weight_bank #(
  parameter int DEPTH = 784,
  parameter int W     = 16,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/perceptron_layer.sv
// N_NEUR parallel signed MAC lanes over one streamed input vector; start->first result 1+N_IN+2+1 cycles.
// x stalls only the sample counter; result stream holds data while a_tready is low.
module perceptron_layer
  import perceptron_pkg::*;
#(
  parameter int N_IN      = 784,
  parameter int N_NEUR    = 4,
  parameter int DATA_W    = 16,
  parameter int WGT_W     = 16,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter bit ACT_RELU  = 1'b1
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic                        start,
  input  logic                        act_relu,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        w_wr_en,
  input  logic [idx_w(N_NEUR)-1:0]    w_wr_neuron,
  input  logic [idx_w(N_IN)-1:0]      w_wr_addr,
  input  logic [WGT_W-1:0]            w_wr_data,
  input  logic                        b_wr_en,
  input  logic [idx_w(N_NEUR)-1:0]    b_wr_neuron,
  input  logic [ACC_W-1:0]            b_wr_data,
  input  logic [DATA_W-1:0]           x_tdata,
  input  logic                        x_tvalid,
  input  logic                        x_tlast,
  output logic                        x_tready,
  output logic [OUT_W-1:0]            a_tdata,
  output logic                        a_tvalid,
  output logic                        a_tlast,
  input  logic                        a_tready
);

  localparam int NW = idx_w(N_NEUR);
  localparam int AW = idx_w(N_IN);
  localparam int PW = DATA_W + WGT_W;
  localparam logic [AW-1:0] LAST_IDX  = AW'(N_IN - 1);
  localparam logic [NW-1:0] LAST_NEUR = NW'(N_NEUR - 1);

  state_e                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic                      flush_q, flush_d;
  logic [NW-1:0]             idx_q, idx_d;
  logic                      err_q, err_d;
  logic                      relu_q, relu_d;
  logic                      done_q, done_d;
  logic                      clr_acc;
  logic                      beat;
  logic                      idle;
  logic                      v1_q;
  logic signed [DATA_W-1:0]  x1_q;
  logic [OUT_W-1:0]          res_all [N_NEUR];

  assign idle     = (state_q == ST_IDLE);
  assign x_tready = (state_q == ST_LOAD);
  assign beat     = x_tvalid && x_tready;
  assign busy     = !idle;
  assign done     = done_q;
  assign err      = err_q;
  assign a_tvalid = (state_q == ST_OUT);
  assign a_tlast  = a_tvalid && (idx_q == LAST_NEUR);
  assign a_tdata  = a_tvalid ? res_all[idx_q] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    idx_d   = idx_q;
    err_d   = err_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    clr_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          relu_d  = act_relu;
          clr_acc = 1'b1;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          // tlast must coincide exactly with the final sample; either mismatch is flagged.
          if ((cnt_q == LAST_IDX) != x_tlast) err_d = 1'b1;
          if ((cnt_q == LAST_IDX) || x_tlast) begin
            state_d = ST_FLUSH;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q) state_d = ST_POST;
        else flush_d = 1'b1;
      end
      ST_POST: begin
        state_d = ST_OUT;
        idx_d   = '0;
      end
      ST_OUT: begin
        if (a_tready) begin
          if (idx_q == LAST_NEUR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + NW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      relu_q  <= ACT_RELU;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      x1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
      // x rides alongside the RAM read so it meets its weight one cycle later.
      v1_q    <= beat;
      if (beat) x1_q <= x_tdata;
    end
  end

  for (genvar n = 0; n < N_NEUR; n++) begin : g_lane
    logic signed [WGT_W-1:0] w_rd;
    logic signed [PW-1:0]    prod_full;
    logic signed [ACC_W-1:0] prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] res_q;
    logic                    w_we;
    logic                    b_we;

    assign w_we = w_wr_en && idle && (int'(w_wr_neuron) == n) && (int'(w_wr_addr) < N_IN);
    assign b_we = b_wr_en && idle && (int'(b_wr_neuron) == n);

    weight_bank #(
      .DEPTH (N_IN),
      .W     (WGT_W),
      .AW    (AW)
    ) u_bank (
      .clk_i   (s_axi_aclk),
      .we_i    (w_we),
      .waddr_i (w_wr_addr),
      .wdata_i (w_wr_data),
      .raddr_i (cnt_q),
      .rdata_o (w_rd)
    );

    assign prod_full = x1_q * w_rd;
    assign sum       = acc_q + bias_q;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
        prod_q <= '0;
        acc_q  <= '0;
        bias_q <= '0;
        res_q  <= '0;
      end else begin
        prod_q <= v1_q ? ACC_W'(prod_full) : '0;
        if (clr_acc) acc_q <= '0;
        else if ((state_q == ST_LOAD) || (state_q == ST_FLUSH)) acc_q <= acc_q + prod_q;
        if (b_we) bias_q <= b_wr_data;
        if (state_q == ST_POST)
          res_q <= OUT_W'(shift_relu_sat(MAX_W'(sum), FRAC_BITS, OUT_W, relu_q));
      end
    end

    assign res_all[n] = res_q;
  end

endmodule
